// File: rtl/gpu_frontend_pkg.sv
// Shared definitions for the SPI scene frontend.
//  - SPI command byte codes
//  - op_e: decoded command class used by the scene register block
//  - frame_bits(): frame length for a given payload width (command byte plus
//    the payload rounded up to whole bytes)
package gpu_frontend_pkg;

  localparam logic [7:0] CMD_WRITE_BASE  = 8'h80;  // | poly index
  localparam logic [7:0] CMD_CLEAR_BASE  = 8'h40;  // | poly index
  localparam logic [7:0] CMD_CLEAR_ALL   = 8'h3F;
  localparam logic [7:0] CMD_SCREEN_ON   = 8'h21;
  localparam logic [7:0] CMD_SCREEN_OFF  = 8'h20;
  localparam logic [7:0] CMD_SET_BG      = 8'h01;
  localparam logic [7:0] CMD_READ_ID     = 8'h00;
  localparam logic [7:0] CMD_READ_STATUS = 8'h02;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_WRITE,
    OP_CLEAR,
    OP_CLEAR_ALL,
    OP_SCREEN_ON,
    OP_SCREEN_OFF,
    OP_SET_BG
  } op_e;

  function automatic int frame_bits(input int pay_w);
    return 8 + 8 * ((pay_w + 7) / 8);
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver, LSB first, in the clk domain.
//  clk, rst_n      system clock, synchronous active-low reset
//  cs_in, sck_in,  raw asynchronous SPI pins
//  mosi_in
//  accept_en       bit-accept gate (blanking window / screen off)
//  frame           received bits, bit k = k-th bit received
//  frame_done      1-clk pulse: frame complete, frame bus holds all bits
//  cmd_byte_valid  1-clk pulse: frame[7:0] holds the command byte
//  sck_fall        synchronised SCK falling edge
//  cs_high         synchronised chip-select deasserted
//  frame_err       1-clk pulse: CS rose with a partial frame
module spi_frame_rx
  import gpu_frontend_pkg::*;
#(
  parameter int FRAME_BITS = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_in,
  input  logic                  sck_in,
  input  logic                  mosi_in,
  input  logic                  accept_en,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_done,
  output logic                  cmd_byte_valid,
  output logic                  sck_fall,
  output logic                  cs_high,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(7);

  logic [1:0]       cs_s, mosi_s;
  logic [2:0]       sck_s;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             sck_rise, bit_take;

  assign sck_rise = (sck_s[2:1] == 2'b01);
  assign sck_fall = (sck_s[2:1] == 2'b10);
  assign cs_high  = cs_s[1];
  // armed is only set by an observed CS-high, so a frame cut by reset
  // cannot resume from bit 0 with its remaining bits.
  assign bit_take = sck_rise & ~cs_high & armed & accept_en & (cnt < CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s           <= '0;
      mosi_s         <= '0;
      sck_s          <= '0;
      cnt            <= '0;
      frame          <= '0;
      armed          <= 1'b0;
      frame_done     <= 1'b0;
      cmd_byte_valid <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      cs_s           <= {cs_s[0], cs_in};
      mosi_s         <= {mosi_s[0], mosi_in};
      sck_s          <= {sck_s[1:0], sck_in};
      frame_done     <= 1'b0;
      cmd_byte_valid <= 1'b0;
      frame_err      <= 1'b0;
      if (cs_high) begin
        cnt       <= '0;
        frame     <= '0;
        armed     <= 1'b1;
        frame_err <= (cnt != '0) && (cnt < CNT_MAX);
      end else if (bit_take) begin
        frame[cnt]     <= mosi_s[1];
        cnt            <= cnt + 1'b1;
        // pulses line up with the cycle where cnt first shows the new count
        frame_done     <= (cnt == CNT_LAST);
        cmd_byte_valid <= (cnt == CNT_CMD);
      end
    end
  end

endmodule

// File: rtl/spi_poly_frontend_mp.sv
// SPI command frontend holding scene state for NUM_POLY polygons.
//  clk, rst_n         system clock, synchronous active-low reset
//  cs_in/sck_in/mosi_in  raw SPI pins (mode 0, LSB first)
//  en_load            blanking window; bits accepted when 1 or screen off
//  miso_out, miso_oe  readback data and its output enable
//  bg_color_out       background colour
//  poly_color, v{0,1,2}_x, v{0,1,2}_y, poly_depth
//                     packed per-polygon fields, polygon i in slice i
//  poly_en            per-polygon enable
//  en_screen          screen enable
//  frame_err          1-clk pulse on a truncated frame
module spi_poly_frontend_mp
  import gpu_frontend_pkg::*;
#(
  parameter int         NUM_POLY  = 4,
  parameter int         X_W       = 7,
  parameter int         Y_W       = 6,
  parameter int         COLOR_W   = 6,
  parameter int         DEPTH_W   = 3,
  parameter logic [7:0] DEVICE_ID = 8'hB6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs_in,
  input  logic                        sck_in,
  input  logic                        mosi_in,
  input  logic                        en_load,
  output logic                        miso_out,
  output logic                        miso_oe,
  output logic [COLOR_W-1:0]          bg_color_out,
  output logic [NUM_POLY*COLOR_W-1:0] poly_color,
  output logic [NUM_POLY*X_W-1:0]     v0_x,
  output logic [NUM_POLY*X_W-1:0]     v1_x,
  output logic [NUM_POLY*X_W-1:0]     v2_x,
  output logic [NUM_POLY*Y_W-1:0]     v0_y,
  output logic [NUM_POLY*Y_W-1:0]     v1_y,
  output logic [NUM_POLY*Y_W-1:0]     v2_y,
  output logic [NUM_POLY*DEPTH_W-1:0] poly_depth,
  output logic [NUM_POLY-1:0]         poly_en,
  output logic                        en_screen,
  output logic                        frame_err
);

  localparam int PAY_W      = COLOR_W + 3*X_W + 3*Y_W + DEPTH_W;
  localparam int FRAME_BITS = frame_bits(PAY_W);

  logic [FRAME_BITS-1:0] frame;
  logic frame_done, cmd_byte_valid, sck_fall, cs_high;

  spi_frame_rx #(.FRAME_BITS(FRAME_BITS)) u_rx (
    .clk            (clk),
    .rst_n          (rst_n),
    .cs_in          (cs_in),
    .sck_in         (sck_in),
    .mosi_in        (mosi_in),
    .accept_en      (en_load | ~en_screen),
    .frame          (frame),
    .frame_done     (frame_done),
    .cmd_byte_valid (cmd_byte_valid),
    .sck_fall       (sck_fall),
    .cs_high        (cs_high),
    .frame_err      (frame_err)
  );

  // ---- command / payload decode ----
  logic [7:0]                cmd;
  logic [3:0]                idx;
  logic                      idx_ok;
  logic [PAY_W-1:0]          pay;
  logic [COLOR_W-1:0]        p_color;
  logic [2:0][X_W-1:0]       p_x;
  logic [2:0][Y_W-1:0]       p_y;
  logic [DEPTH_W-1:0]        p_depth;
  op_e                       op;

  assign cmd    = frame[7:0];
  assign idx    = cmd[3:0];
  assign idx_ok = int'(idx) < NUM_POLY;
  assign pay    = frame[8 +: PAY_W];

  always_comb begin
    p_color = pay[0 +: COLOR_W];
    p_depth = pay[COLOR_W + 3*X_W + 3*Y_W +: DEPTH_W];
    for (int j = 0; j < 3; j++) begin
      p_x[j] = pay[COLOR_W + j*X_W +: X_W];
      p_y[j] = pay[COLOR_W + 3*X_W + j*Y_W +: Y_W];
    end
  end

  always_comb begin
    op = OP_NONE;
    if (cmd[7:4] == CMD_WRITE_BASE[7:4] && idx_ok)      op = OP_WRITE;
    else if (cmd[7:4] == CMD_CLEAR_BASE[7:4] && idx_ok) op = OP_CLEAR;
    else begin
      case (cmd)
        CMD_CLEAR_ALL:  op = OP_CLEAR_ALL;
        CMD_SCREEN_ON:  op = OP_SCREEN_ON;
        CMD_SCREEN_OFF: op = OP_SCREEN_OFF;
        CMD_SET_BG:     op = OP_SET_BG;
        default:        op = OP_NONE;   // reads and unknown codes
      endcase
    end
  end

  // ---- scene registers ----
  logic [NUM_POLY-1:0][COLOR_W-1:0]   color_q;
  logic [2:0][NUM_POLY-1:0][X_W-1:0]  vx_q;
  logic [2:0][NUM_POLY-1:0][Y_W-1:0]  vy_q;
  logic [NUM_POLY-1:0][DEPTH_W-1:0]   depth_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color_q      <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      depth_q      <= '0;
      poly_en      <= '0;
      en_screen    <= 1'b0;
      bg_color_out <= '0;
    end else if (frame_done) begin
      case (op)
        OP_WRITE, OP_CLEAR: begin
          for (int i = 0; i < NUM_POLY; i++) begin
            if (idx == 4'(i)) begin
              color_q[i] <= (op == OP_WRITE) ? p_color : '0;
              depth_q[i] <= (op == OP_WRITE) ? p_depth : '0;
              poly_en[i] <= (op == OP_WRITE);
              for (int j = 0; j < 3; j++) begin
                vx_q[j][i] <= (op == OP_WRITE) ? p_x[j] : '0;
                vy_q[j][i] <= (op == OP_WRITE) ? p_y[j] : '0;
              end
            end
          end
        end
        OP_CLEAR_ALL: begin
          color_q <= '0;
          vx_q    <= '0;
          vy_q    <= '0;
          depth_q <= '0;
          poly_en <= '0;
        end
        OP_SCREEN_ON:  en_screen    <= 1'b1;
        OP_SCREEN_OFF: en_screen    <= 1'b0;
        OP_SET_BG:     bg_color_out <= p_color;
        default: ;
      endcase
    end
  end

  assign poly_color = color_q;
  assign v0_x       = vx_q[0];
  assign v1_x       = vx_q[1];
  assign v2_x       = vx_q[2];
  assign v0_y       = vy_q[0];
  assign v1_y       = vy_q[1];
  assign v2_y       = vy_q[2];
  assign poly_depth = depth_q;

  // ---- MISO readback ----
  // Loaded once the command byte is in; each SCK fall presents the next bit,
  // so the host samples bit n of the reply on rising edge 8+n. Zeros shift
  // in behind, leaving miso_out at 0 after the eighth bit.
  logic [7:0] tx;
  logic [7:0] status;

  assign status = 8'({en_screen, poly_en});

  always_ff @(posedge clk) begin
    if (!rst_n || cs_high) begin
      tx       <= '0;
      miso_out <= 1'b0;
      miso_oe  <= 1'b0;
    end else if (cmd_byte_valid && (cmd == CMD_READ_ID || cmd == CMD_READ_STATUS)) begin
      tx      <= (cmd == CMD_READ_ID) ? DEVICE_ID : status;
      miso_oe <= 1'b1;
    end else if (sck_fall && miso_oe) begin
      miso_out <= tx[0];
      tx       <= {1'b0, tx[7:1]};
    end
  end

endmodule

// File: tb/tb_spi_poly_frontend_mp.sv
// Scoreboard bench for spi_poly_frontend_mp (default parameters).
// Stimulus pushes expected scene snapshots, frame_err pulses, miso_oe drops
// and MISO bit samples into queues; monitors pop and compare whenever the DUT
// shows the matching output activity.
module tb_spi_poly_frontend_mp;

  localparam int H  = 6;  // SCK half period in clk cycles
  localparam int SW = 6 + 4*6 + 3*4*7 + 3*4*6 + 4*3 + 4 + 1;

  typedef struct {
    string         name;
    int            at;    // expected cycle, or bit index for MISO samples
    logic [SW-1:0] exp;
  } rec_t;

  logic clk, rst_n, cs_in, sck_in, mosi_in, en_load;
  logic miso_out, miso_oe, en_screen, frame_err;
  logic [5:0]  bg_color_out;
  logic [23:0] poly_color;
  logic [27:0] v0_x, v1_x, v2_x;
  logic [23:0] v0_y, v1_y, v2_y;
  logic [11:0] poly_depth;
  logic [3:0]  poly_en;

  spi_poly_frontend_mp dut (
    .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .sck_in(sck_in), .mosi_in(mosi_in),
    .en_load(en_load), .miso_out(miso_out), .miso_oe(miso_oe),
    .bg_color_out(bg_color_out), .poly_color(poly_color),
    .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x), .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
    .poly_depth(poly_depth), .poly_en(poly_en), .en_screen(en_screen),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int cur_bit = 0;

  rec_t upd_q[$], chk_q[$], err_q[$], oe_q[$], miso_q[$];

  // expected scene model, filled with hand-chosen values by the stimulus
  logic [5:0] m_col [4];
  logic [6:0] m_x [3][4];
  logic [5:0] m_y [3][4];
  logic [2:0] m_d [4];
  logic [3:0] m_en;
  logic       m_scr;
  logic [5:0] m_bg;

  task automatic check(input bit ok, input string nm, input logic [SW-1:0] got,
                       input logic [SW-1:0] want, input int gc, input int wc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h (cyc %0d) want %h (cyc %0d)", nm, got, gc, want, wc);
    end
  endtask

  function automatic logic [SW-1:0] dut_snap();
    return {bg_color_out, poly_color, v0_x, v1_x, v2_x, v0_y, v1_y, v2_y,
            poly_depth, poly_en, en_screen};
  endfunction

  function automatic logic [SW-1:0] mdl_snap();
    logic [23:0] pc, y0, y1, y2;
    logic [27:0] x0, x1, x2;
    logic [11:0] pd;
    for (int i = 0; i < 4; i++) begin
      pc[i*6 +: 6] = m_col[i];
      x0[i*7 +: 7] = m_x[0][i];
      x1[i*7 +: 7] = m_x[1][i];
      x2[i*7 +: 7] = m_x[2][i];
      y0[i*6 +: 6] = m_y[0][i];
      y1[i*6 +: 6] = m_y[1][i];
      y2[i*6 +: 6] = m_y[2][i];
      pd[i*3 +: 3] = m_d[i];
    end
    return {m_bg, pc, x0, x1, x2, y0, y1, y2, pd, m_en, m_scr};
  endfunction

  task automatic clr_polys();
    for (int i = 0; i < 4; i++) begin
      m_col[i] = '0; m_d[i] = '0;
      for (int j = 0; j < 3; j++) begin m_x[j][i] = '0; m_y[j][i] = '0; end
    end
    m_en = '0;
  endtask

  task automatic clr_model();
    clr_polys();
    m_scr = 1'b0;
    m_bg  = '0;
  endtask

  task automatic set_poly(input int i, input logic [5:0] col,
                          input logic [6:0] x0, input logic [6:0] x1, input logic [6:0] x2,
                          input logic [5:0] y0, input logic [5:0] y1, input logic [5:0] y2,
                          input logic [2:0] d);
    m_col[i] = col; m_d[i] = d; m_en[i] = 1'b1;
    m_x[0][i] = x0; m_x[1][i] = x1; m_x[2][i] = x2;
    m_y[0][i] = y0; m_y[1][i] = y1; m_y[2][i] = y2;
  endtask

  function automatic logic [55:0] mk(input logic [7:0] c, input logic [5:0] col,
                                     input logic [6:0] x0, input logic [6:0] x1, input logic [6:0] x2,
                                     input logic [5:0] y0, input logic [5:0] y1, input logic [5:0] y2,
                                     input logic [2:0] d);
    return {d, y2, y1, y0, x2, x1, x0, col, c};
  endfunction

  // expected {miso_oe, miso_out} at the rising edge of bit indices 7..16
  task automatic push_read(input logic [7:0] val, input string nm);
    miso_q.push_back('{name: {nm, "_pre"}, at: 7, exp: SW'(2'b00)});
    for (int k = 0; k < 8; k++)
      miso_q.push_back('{name: $sformatf("%s_bit%0d", nm, k), at: 8 + k,
                         exp: SW'({1'b1, val[k]})});
    miso_q.push_back('{name: {nm, "_tail"}, at: 16, exp: SW'(2'b10)});
  endtask

  task automatic quiet(input string nm);
    chk_q.push_back('{name: nm, at: cyc + 2, exp: mdl_snap()});
  endtask

  // exp_upd: model already holds the state expected 4 clks after the last
  // SCK rise (2 sync FFs + edge detect + shift, then the commit clk).
  task automatic send(input logic [55:0] f, input int nbits, input int rst_at,
                      input bit exp_upd, input bit exp_err, input bit is_read,
                      input string nm);
    cs_in = 1'b0;
    repeat (H) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        clr_model();
        upd_q.push_back('{name: {nm, "_reset"}, at: cyc + 1, exp: mdl_snap()});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      mosi_in = f[k];
      repeat (H) @(negedge clk);
      cur_bit = k;
      sck_in  = 1'b1;
      if (exp_upd && k == nbits - 1)
        upd_q.push_back('{name: nm, at: cyc + 4, exp: mdl_snap()});
      repeat (H) @(negedge clk);
      sck_in = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs_in = 1'b1;
    if (exp_err) err_q.push_back('{name: {nm, "_frame_err"}, at: cyc + 3, exp: '0});
    if (is_read) oe_q.push_back('{name: {nm, "_oe_drop"}, at: cyc + 3, exp: '0});
    repeat (H) @(negedge clk);
  endtask

  // ---- monitors ----
  initial begin : mon_scene
    logic [SW-1:0] prev, cur;
    rec_t r;
    wait (rst_n === 1'b1);
    @(negedge clk);
    cur = dut_snap();
    check(cur === '0, "reset_scene", cur, '0, cyc, cyc);
    check({miso_oe, miso_out, frame_err} === 3'b000, "reset_miso",
          SW'({miso_oe, miso_out, frame_err}), '0, cyc, cyc);
    prev = cur;
    forever begin
      @(negedge clk);
      cur = dut_snap();
      while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
        r = chk_q.pop_front();
        check(cur === r.exp && r.at == cyc, r.name, cur, r.exp, cyc, r.at);
      end
      if (cur !== prev) begin
        if (upd_q.size() == 0) check(1'b0, "unexpected_update", cur, prev, cyc, -1);
        else begin
          r = upd_q.pop_front();
          check(cur === r.exp && r.at == cyc, r.name, cur, r.exp, cyc, r.at);
        end
      end
      prev = cur;
    end
  end

  initial begin : mon_pulse
    logic prev_oe;
    rec_t r;
    wait (rst_n === 1'b1);
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        if (err_q.size() == 0) check(1'b0, "unexpected_frame_err", 1, 0, cyc, -1);
        else begin
          r = err_q.pop_front();
          check(r.at == cyc, r.name, 1, 1, cyc, r.at);
        end
      end
      if (prev_oe && !miso_oe) begin
        if (oe_q.size() == 0) check(1'b0, "unexpected_oe_drop", 0, 1, cyc, -1);
        else begin
          r = oe_q.pop_front();
          check(r.at == cyc, r.name, 0, 0, cyc, r.at);
        end
      end
      prev_oe = miso_oe;
    end
  end

  always @(posedge sck_in) begin : mon_miso
    rec_t r;
    if (miso_q.size() > 0 && miso_q[0].at == cur_bit) begin
      r = miso_q.pop_front();
      check({miso_oe, miso_out} === r.exp[1:0], r.name, SW'({miso_oe, miso_out}),
            r.exp, cur_bit, r.at);
    end
  end

  // ---- stimulus ----
  initial begin
    cs_in = 1'b1; sck_in = 1'b0; mosi_in = 1'b0; en_load = 1'b1; rst_n = 1'b0;
    clr_model();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // write polygon 1
    set_poly(1, 6'h2A, 7'd5, 7'd90, 7'd40, 6'd3, 6'd10, 6'd60, 3'd5);
    send(mk(8'h81, 6'h2A, 7'd5, 7'd90, 7'd40, 6'd3, 6'd10, 6'd60, 3'd5), 56, -1, 1'b1, 1'b0, 1'b0, "write_p1");

    // index beyond NUM_POLY: nothing moves
    send(mk(8'h85, 6'h2A, 7'd5, 7'd90, 7'd40, 6'd3, 6'd10, 6'd60, 3'd5), 56, -1, 1'b0, 1'b0, 1'b0, "idx_oob");
    quiet("idx_oob_nochange");

    // clear all
    clr_polys();
    send(mk(8'h3F, 6'h0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b1, 1'b0, 1'b0, "clear_all");

    // screen on
    m_scr = 1'b1;
    send(mk(8'h21, 6'h0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b1, 1'b0, 1'b0, "screen_on");

    // outside blanking: frame ignored
    en_load = 1'b0;
    send(mk(8'h01, 6'h15, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b0, 1'b0, 1'b0, "bg_blocked");
    quiet("bg_blocked_nochange");
    en_load = 1'b1;

    // inside blanking: background set
    m_bg = 6'h15;
    send(mk(8'h01, 6'h15, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b1, 1'b0, 1'b0, "bg_set");

    // READ_ID
    push_read(8'hB6, "read_id");
    send(mk(8'h00, 6'h0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b0, 1'b0, 1'b1, "read_id");
    quiet("read_id_nochange");

    // write polygon 0, then READ_STATUS = {screen=1, poly_en=0001}
    set_poly(0, 6'h11, 7'd1, 7'd2, 7'd3, 6'd4, 6'd5, 6'd6, 3'd7);
    send(mk(8'h80, 6'h11, 7'd1, 7'd2, 7'd3, 6'd4, 6'd5, 6'd6, 3'd7), 56, -1, 1'b1, 1'b0, 1'b0, "write_p0");
    push_read(8'h11, "read_status");
    send(mk(8'h02, 6'h0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0, 3'd0), 56, -1, 1'b0, 1'b0, 1'b1, "read_status");
    quiet("read_status_nochange");

    // truncated frame: error pulse, no commit; then a full frame commits
    send(mk(8'h82, 6'h3C, 7'd100, 7'd64, 7'd127, 6'd63, 6'd0, 6'd33, 3'd2), 20, -1, 1'b0, 1'b1, 1'b0, "partial");
    quiet("partial_nochange");
    set_poly(2, 6'h3C, 7'd100, 7'd64, 7'd127, 6'd63, 6'd0, 6'd33, 3'd2);
    send(mk(8'h82, 6'h3C, 7'd100, 7'd64, 7'd127, 6'd63, 6'd0, 6'd33, 3'd2), 56, -1, 1'b1, 1'b0, 1'b0, "write_p2");

    // reset at bit 30: everything 0, rest of frame never commits
    send(mk(8'h83, 6'h3F, 7'd9, 7'd9, 7'd9, 6'd9, 6'd9, 6'd9, 3'd1), 56, 30, 1'b0, 1'b0, 1'b0, "rst_mid");
    quiet("rst_mid_nochange");

    repeat (20) @(negedge clk);
    foreach (upd_q[i])  check(1'b0, {upd_q[i].name, "_missing"}, '0, upd_q[i].exp, cyc, upd_q[i].at);
    foreach (chk_q[i])  check(1'b0, {chk_q[i].name, "_missing"}, '0, chk_q[i].exp, cyc, chk_q[i].at);
    foreach (err_q[i])  check(1'b0, {err_q[i].name, "_missing"}, 0, 1, cyc, err_q[i].at);
    foreach (oe_q[i])   check(1'b0, {oe_q[i].name, "_missing"}, 1, 0, cyc, oe_q[i].at);
    foreach (miso_q[i]) check(1'b0, {miso_q[i].name, "_missing"}, '0, miso_q[i].exp, cyc, miso_q[i].at);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
